trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller.sv | 177 +++++++++++++++++
 tb/tb_trap_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap controller: CSR file, interrupt entry and MRET return sequencing.
// Traps and MRET are accepted as MEM retires; the redirect pulse follows one cycle later.
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic [31:0] pc_mem,
    input  logic        valid_mem,
    input  logic        stall_pipl,
    input  logic        is_csr_mem,
    input  logic        is_mret_mem,
    input  logic [11:0] csr_addr_mem,
    input  logic [1:0]  csr_op_mem,
    input  logic [31:0] csr_wdata_mem,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        mret_exec,
    output logic [31:0] redirect_pc
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

    state_t      state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        mtie_q, mtie_d;
    logic        meie_q, meie_d;
    logic        mtip_q, mtip_d;
    logic        meip_q, meip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        go;
    logic        ext_pend;
    logic        tmr_pend;
    logic        pending;
    logic        mret_acc;
    logic        trap_acc;
    logic        csr_we;
    logic [31:0] csr_new;

    // mtvec/mepc low bits are kept zero on every write, so reads need no masking
    always_comb begin
        case (csr_addr_mem)
            ADDR_MSTATUS: csr_rdata = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
            ADDR_MIE:     csr_rdata = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
            ADDR_MIP:     csr_rdata = {20'd0, meip_q, 3'd0, mtip_q, 7'd0};
            default:      csr_rdata = 32'd0;
        endcase
    end

    always_comb begin
        ext_pend = meie_q & meip_q;
        tmr_pend = mtie_q & mtip_q;
        pending  = mie_q & (ext_pend | tmr_pend);
        go       = valid_mem & ~stall_pipl & (state_q == IDLE);
        mret_acc = go & is_mret_mem;
        trap_acc = go & pending & ~is_mret_mem;

        case (csr_op_mem)
            OP_RW:   csr_new = csr_wdata_mem;
            OP_RS:   csr_new = csr_rdata | csr_wdata_mem;
            OP_RC:   csr_new = csr_rdata & ~csr_wdata_mem;
            default: csr_new = csr_rdata;
        endcase

        // set/clear with a zero mask is a pure read
        csr_we = go & is_csr_mem & (csr_op_mem != 2'b00) & ~trap_acc & ~mret_acc
               & ((csr_op_mem == OP_RW) | (csr_wdata_mem != 32'd0));
    end

    always_comb begin
        state_d  = state_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtie_d   = mtie_q;
        meie_d   = meie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtip_d   = irq_timer_i;
        meip_d   = irq_ext_i;

        case (state_q)
            IDLE: begin
                if (mret_acc) begin
                    state_d = RETURN;
                    mie_d   = mpie_q;
                    mpie_d  = 1'b1;
                end else if (trap_acc) begin
                    state_d  = ENTER;
                    mepc_d   = pc_mem & ALIGN_MASK;
                    mcause_d = ext_pend ? CAUSE_EXT : CAUSE_TIMER;
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
                end else if (csr_we) begin
                    case (csr_addr_mem)
                        ADDR_MSTATUS: begin
                            mie_d  = csr_new[3];
                            mpie_d = csr_new[7];
                        end
                        ADDR_MIE: begin
                            mtie_d = csr_new[7];
                            meie_d = csr_new[11];
                        end
                        ADDR_MTVEC:  mtvec_d  = csr_new & ALIGN_MASK;
                        ADDR_MEPC:   mepc_d   = csr_new & ALIGN_MASK;
                        ADDR_MCAUSE: mcause_d = csr_new;
                        default: ;
                    endcase
                end
            end
            ENTER:   state_d = IDLE;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trap_taken  = (state_q == ENTER);
        mret_exec   = (state_q == RETURN);
        redirect_pc = 32'd0;
        if (state_q == ENTER) begin
            redirect_pc = mtvec_q;
        end else if (state_q == RETURN) begin
            redirect_pc = mepc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtip_q   <= 1'b0;
            meip_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET & ALIGN_MASK;
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtie_q   <= mtie_d;
            meie_q   <= meie_d;
            mtip_q   <= mtip_d;
            meip_q   <= meip_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the trap/CSR rules.
module tb_trap_controller;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0203;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        irq_timer_i;
    logic        irq_ext_i;
    logic [31:0] pc_mem;
    logic        valid_mem;
    logic        stall_pipl;
    logic        is_csr_mem;
    logic        is_mret_mem;
    logic [11:0] csr_addr_mem;
    logic [1:0]  csr_op_mem;
    logic [31:0] csr_wdata_mem;
    logic [31:0] csr_rdata;
    logic        trap_taken;
    logic        mret_exec;
    logic [31:0] redirect_pc;

    int vectors = 0;
    int miscompares = 0;

    // model state: architectural bits plus which redirect (0 none, 1 trap, 2 mret) is in flight
    bit          m_mie, m_mpie, m_mtie, m_meie, m_mtip, m_meip;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    int          m_pulse;

    logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};

    always #5 clk = ~clk;

    trap_controller #(.MTVEC_RESET(MTVEC_RST)) dut (
        .clk(clk), .reset_n(reset_n),
        .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
        .pc_mem(pc_mem), .valid_mem(valid_mem), .stall_pipl(stall_pipl),
        .is_csr_mem(is_csr_mem), .is_mret_mem(is_mret_mem),
        .csr_addr_mem(csr_addr_mem), .csr_op_mem(csr_op_mem), .csr_wdata_mem(csr_wdata_mem),
        .csr_rdata(csr_rdata), .trap_taken(trap_taken), .mret_exec(mret_exec),
        .redirect_pc(redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h304: return (m_meie ? 32'h800 : 32'h0) + (m_mtie ? 32'h80 : 32'h0);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (m_meip ? 32'h800 : 32'h0) + (m_mtip ? 32'h80 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write();
        logic [31:0] old_v, new_v;
        old_v = m_read(csr_addr_mem);
        if (csr_op_mem == 2'b01) new_v = csr_wdata_mem;
        else if (csr_op_mem == 2'b10) new_v = old_v | csr_wdata_mem;
        else new_v = old_v & ~csr_wdata_mem;
        if (csr_op_mem != 2'b01 && csr_wdata_mem == 32'h0) return;
        case (csr_addr_mem)
            12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
            12'h304: begin m_mtie = new_v[7]; m_meie = new_v[11]; end
            12'h305: m_mtvec = new_v & 32'hFFFF_FFFC;
            12'h341: m_mepc = new_v & 32'hFFFF_FFFC;
            12'h342: m_mcause = new_v;
            default: ;
        endcase
    endtask

    task automatic model_edge();
        bit take_ext, pend, go;
        if (!reset_n) begin
            m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_mtip = 0; m_meip = 0;
            m_mtvec = MTVEC_RST & 32'hFFFF_FFFC;
            m_mepc = 0; m_mcause = 0; m_pulse = 0;
            return;
        end
        take_ext = m_mie && m_meie && m_meip;
        pend = take_ext || (m_mie && m_mtie && m_mtip);
        go = (m_pulse == 0) && valid_mem && !stall_pipl;
        if (go && is_mret_mem) begin
            m_mie = m_mpie; m_mpie = 1; m_pulse = 2;
        end else if (go && pend) begin
            m_mepc = pc_mem & 32'hFFFF_FFFC;
            m_mcause = take_ext ? 32'h8000_000B : 32'h8000_0007;
            m_mpie = m_mie; m_mie = 0; m_pulse = 1;
        end else begin
            if (go && is_csr_mem && csr_op_mem != 2'b00) model_write();
            m_pulse = 0;
        end
        m_mtip = irq_timer_i;
        m_meip = irq_ext_i;
    endtask

    task automatic step();
        logic [31:0] exp_pc;
        @(posedge clk);
        model_edge();
        #1;
        exp_pc = (m_pulse == 1) ? m_mtvec : (m_pulse == 2) ? m_mepc : 32'h0;
        check("trap_taken", {31'd0, trap_taken}, {31'd0, (m_pulse == 1)});
        check("mret_exec", {31'd0, mret_exec}, {31'd0, (m_pulse == 2)});
        check("redirect_pc", redirect_pc, exp_pc);
        check("csr_rdata", csr_rdata, m_read(csr_addr_mem));
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_mem = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_op(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        is_csr_mem = 1; csr_addr_mem = a; csr_op_mem = op; csr_wdata_mem = d;
        step();
        is_csr_mem = 0; csr_op_mem = 2'b00;
    endtask

    task automatic mret_then_idle();
        is_mret_mem = 1;
        step();
        is_mret_mem = 0;
        step();
    endtask

    initial begin
        int r;
        reset_n = 0; irq_timer_i = 0; irq_ext_i = 0; pc_mem = 0; valid_mem = 1;
        stall_pipl = 0; is_csr_mem = 0; is_mret_mem = 0; csr_addr_mem = 0;
        csr_op_mem = 0; csr_wdata_mem = 0;
        step(); step();
        peek("rst_mtvec", 12'h305, 32'h200);
        peek("rst_mstatus", 12'h300, 32'h0);
        reset_n = 1;

        // timer trap entry
        csr_op(12'h305, 2'b01, 32'h100);
        csr_op(12'h304, 2'b01, 32'h80);
        csr_op(12'h300, 2'b01, 32'h8);
        pc_mem = 32'h40; irq_timer_i = 1;
        step();
        check("lat_mip_edge", {31'd0, trap_taken}, 32'd0);
        step();
        check("trap_pulse", {31'd0, trap_taken}, 32'd1);
        check("trap_vec", redirect_pc, 32'h100);
        pc_mem = 32'h44;
        step();
        check("trap_once", {31'd0, trap_taken}, 32'd0);
        peek("trap_mepc", 12'h341, 32'h40);
        peek("trap_mcause", 12'h342, 32'h8000_0007);
        peek("trap_mstatus", 12'h300, 32'h80);

        // MRET return
        irq_timer_i = 0;
        step(); step();
        is_mret_mem = 1;
        step();
        check("mret_pulse", {31'd0, mret_exec}, 32'd1);
        check("mret_target", redirect_pc, 32'h40);
        is_mret_mem = 0;
        peek("mret_mstatus", 12'h300, 32'h88);
        step();
        check("mret_once", {31'd0, mret_exec}, 32'd0);

        // MRET beats a simultaneous pending interrupt
        csr_op(12'h341, 2'b01, 32'h80);
        valid_mem = 0; irq_timer_i = 1;
        step(); step();
        check("bubble_hold", {31'd0, trap_taken}, 32'd0);
        valid_mem = 1; is_mret_mem = 1; pc_mem = 32'h1000;
        step();
        check("mret_first", {31'd0, mret_exec}, 32'd1);
        check("mret_first_no_trap", {31'd0, trap_taken}, 32'd0);
        is_mret_mem = 0; pc_mem = 32'h80;
        step();
        step();
        check("trap_after_mret", {31'd0, trap_taken}, 32'd1);
        pc_mem = 32'h84;
        step();
        peek("trap_after_mret_mepc", 12'h341, 32'h80);

        // stall holds a pending interrupt
        irq_timer_i = 0;
        step(); step();
        is_mret_mem = 1;
        step();
        is_mret_mem = 0; stall_pipl = 1; irq_timer_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_hold", {31'd0, trap_taken}, 32'd0);
        end
        stall_pipl = 0;
        step();
        check("stall_release", {31'd0, trap_taken}, 32'd1);
        step();

        // external has priority over timer
        irq_timer_i = 0;
        step(); step();
        mret_then_idle();
        csr_op(12'h304, 2'b01, 32'h880);
        irq_timer_i = 1; irq_ext_i = 1;
        step(); step();
        check("both_trap", {31'd0, trap_taken}, 32'd1);
        step();
        peek("both_mcause", 12'h342, 32'h8000_000B);

        // CSRRC of MIE on the trap-accept edge is suppressed
        irq_timer_i = 0; irq_ext_i = 0;
        step(); step();
        mret_then_idle();
        valid_mem = 0; irq_ext_i = 1;
        step(); step();
        valid_mem = 1;
        csr_op(12'h300, 2'b11, 32'h8);
        check("rc_trap_wins", {31'd0, trap_taken}, 32'd1);
        step();
        peek("rc_mstatus", 12'h300, 32'h80);

        // ignored writes and zero-mask set/clear
        csr_op(12'h344, 2'b01, 32'hFFFF_FFFF);
        csr_op(12'h7C0, 2'b01, 32'h0000_FFFF);
        csr_op(12'h342, 2'b10, 32'h0);
        csr_op(12'h342, 2'b11, 32'h0);
        peek("unimpl_read", 12'h7C0, 32'h0);
        peek("mip_ro", 12'h344, 32'h800);
        peek("zero_mask", 12'h342, 32'h8000_000B);

        // reset during ENTER aborts the pulse
        is_mret_mem = 1;
        step();
        is_mret_mem = 0;
        step(); step();
        check("pre_reset_trap", {31'd0, trap_taken}, 32'd1);
        reset_n = 0;
        step();
        check("reset_abort", {31'd0, trap_taken}, 32'd0);
        check("reset_redirect", redirect_pc, 32'd0);
        peek("reset_mepc", 12'h341, 32'h0);
        reset_n = 1; irq_ext_i = 0;

        for (int i = 0; i < 800; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) irq_timer_i = ~irq_timer_i;
            if ($urandom_range(0, 9) == 0) irq_ext_i = ~irq_ext_i;
            valid_mem  = ($urandom_range(0, 9) < 8);
            stall_pipl = ($urandom_range(0, 9) < 2);
            pc_mem = $urandom;
            r = $urandom_range(0, 19);
            is_mret_mem = (r == 0);
            is_csr_mem  = (r >= 10);
            csr_addr_mem = addrs[$urandom_range(0, 6)];
            csr_op_mem = 2'($urandom_range(0, 3));
            csr_wdata_mem = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
